// File: rtl/pin_verifier.sv
// pin_verifier
//   PIN check engine for the door-lock controller. A rising edge on pin_valid
//   latches pin_digits. The PIN is then compared against the factory master
//   (when no master has been configured), or against the configured master
//   followed by the enabled user slots. One classified result is presented and
//   held until res_ack. MAX_FAILS consecutive failures start a lockout that
//   lasts LOCKOUT_CYC cycles.
//
//   Handshake: a result is offered when res_valid=1, with exactly one of
//   res_fail / res_master / res_default / res_user set. It is consumed on the
//   first clock edge at which res_valid=1 and res_ack=1 are both seen. All
//   res_* outputs and match_idx clear on the following cycle. res_ack seen at
//   any other time has no effect.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   pin_valid       submission strobe (its rising edge marks a new PIN)
//   pin_digits      submitted PIN, digit1 in the MSBs
//   master_pin      configured master PIN
//   master_set      1 = master_pin is configured
//   user_pins       user slot i at bits [i*P +: P]
//   user_en         per-slot enable
//   res_ack         consumer acknowledge
//   res_valid       result held valid
//   res_fail/res_master/res_default/res_user   one-hot classification
//   match_idx       matched user slot (0 when no slot matched)
//   locked          lockout active
//   fail_count      consecutive-failure count
//   state_dbg       current FSM state (IDLE=0, COMPARE=1, RESULT=2, LOCKOUT=3)
module pin_verifier #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int NUM_PINS    = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_MASTER = 16'h1234,
    localparam int P     = DIGITS * DIGIT_W,
    localparam int IDX_W = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
    localparam int FC_W  = $clog2(MAX_FAILS + 1),
    localparam int LC_W  = $clog2(LOCKOUT_CYC + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pin_valid,
    input  logic [P-1:0]          pin_digits,
    input  logic [P-1:0]          master_pin,
    input  logic                  master_set,
    input  logic [NUM_PINS*P-1:0] user_pins,
    input  logic [NUM_PINS-1:0]   user_en,
    input  logic                  res_ack,
    output logic                  res_valid,
    output logic                  res_fail,
    output logic                  res_master,
    output logic                  res_default,
    output logic                  res_user,
    output logic [IDX_W-1:0]      match_idx,
    output logic                  locked,
    output logic [FC_W-1:0]       fail_count,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESULT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t              state;
    logic                pv_q;        // previous pin_valid, for edge detection
    logic [P-1:0]        pin_q;
    logic                cmp_phase;   // 0: register raw hits, 1: classify
    logic                hit_default;
    logic                hit_master;
    logic                ms_q;
    logic [NUM_PINS-1:0] hit_user;
    logic [LC_W-1:0]     lock_cnt;

    logic                pv_rise;
    logic                user_any;
    logic [IDX_W-1:0]    user_idx;
    logic                cls_ok;
    logic [FC_W-1:0]     fail_next;

    assign pv_rise   = pin_valid & ~pv_q;
    assign state_dbg = state;

    // Lowest-numbered enabled slot wins, so scan downward and let the
    // lower indices overwrite the higher ones.
    always_comb begin
        user_any = 1'b0;
        user_idx = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (hit_user[i]) begin
                user_any = 1'b1;
                user_idx = IDX_W'(i);
            end
        end
    end

    assign cls_ok    = ms_q ? (hit_master | user_any) : hit_default;
    assign fail_next = (fail_count == FC_W'(MAX_FAILS)) ? fail_count
                                                        : fail_count + FC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pv_q        <= 1'b1;  // a level held high through reset is not an edge
            pin_q       <= '0;
            cmp_phase   <= 1'b0;
            hit_default <= 1'b0;
            hit_master  <= 1'b0;
            ms_q        <= 1'b0;
            hit_user    <= '0;
            lock_cnt    <= '0;
            res_valid   <= 1'b0;
            res_fail    <= 1'b0;
            res_master  <= 1'b0;
            res_default <= 1'b0;
            res_user    <= 1'b0;
            match_idx   <= '0;
            locked      <= 1'b0;
            fail_count  <= '0;
        end else begin
            // The edge detector follows pin_valid in every state, so a level
            // held high outside IDLE cannot be replayed later.
            pv_q <= pin_valid;
            case (state)
                IDLE: begin
                    if (pv_rise) begin
                        pin_q     <= pin_digits;
                        cmp_phase <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (!cmp_phase) begin
                        // Configuration is sampled only here.
                        hit_default <= (pin_q == DEFAULT_MASTER);
                        hit_master  <= (pin_q == master_pin);
                        ms_q        <= master_set;
                        for (int i = 0; i < NUM_PINS; i++) begin
                            hit_user[i] <= user_en[i] && (pin_q == user_pins[i*P +: P]);
                        end
                        cmp_phase <= 1'b1;
                    end else begin
                        res_valid <= 1'b1;
                        if (ms_q) begin
                            if (hit_master) begin
                                res_master <= 1'b1;
                            end else if (user_any) begin
                                res_user  <= 1'b1;
                                match_idx <= user_idx;
                            end else begin
                                res_fail <= 1'b1;
                            end
                        end else if (hit_default) begin
                            res_default <= 1'b1;
                        end else begin
                            res_fail <= 1'b1;
                        end
                        fail_count <= cls_ok ? '0 : fail_next;
                        state      <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ack) begin
                        res_valid   <= 1'b0;
                        res_fail    <= 1'b0;
                        res_master  <= 1'b0;
                        res_default <= 1'b0;
                        res_user    <= 1'b0;
                        match_idx   <= '0;
                        if (fail_count == FC_W'(MAX_FAILS)) begin
                            locked   <= 1'b1;
                            lock_cnt <= LC_W'(LOCKOUT_CYC - 1);
                            state    <= LOCKOUT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == '0) begin
                        locked     <= 1'b0;
                        fail_count <= '0;
                        state      <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_verifier.sv
module tb_pin_verifier;
    localparam int P  = 16;
    localparam int NP = 4;
    localparam int MF = 3;
    localparam int LC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pin_valid = 1'b1;
    logic [P-1:0]  pin_digits = '0;
    logic [P-1:0]  mpin = '0;
    logic          ms = 1'b0;
    logic [NP*P-1:0] upins = '0;
    logic [NP-1:0] uen = '0;
    logic          res_ack = 1'b0;
    logic          res_valid, res_fail, res_master, res_default, res_user;
    logic [1:0]    match_idx;
    logic          locked;
    logic [1:0]    fail_count;
    logic [1:0]    state_dbg;

    int n_pass = 0;
    int n_total = 0;
    int m_fails = 0;
    logic [6:0] exp_q[$];

    pin_verifier #(
        .DIGITS(4), .DIGIT_W(4), .NUM_PINS(NP), .MAX_FAILS(MF),
        .LOCKOUT_CYC(LC), .DEFAULT_MASTER(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .pin_valid(pin_valid), .pin_digits(pin_digits),
        .master_pin(mpin), .master_set(ms), .user_pins(upins), .user_en(uen),
        .res_ack(res_ack), .res_valid(res_valid), .res_fail(res_fail),
        .res_master(res_master), .res_default(res_default), .res_user(res_user),
        .match_idx(match_idx), .locked(locked), .fail_count(fail_count),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed result as {valid, fail, master, default, user, idx[1:0]}.
    function automatic logic [6:0] obs_now();
        return {res_valid, res_fail, res_master, res_default, res_user, match_idx};
    endfunction

    // Reference model: classification straight from the rules.
    function automatic logic [6:0] model(input logic [P-1:0] pin);
        if (!ms) return (pin == 16'h1234) ? 7'b1_0010_00 : 7'b1_1000_00;
        if (pin == mpin) return 7'b1_0100_00;
        for (int i = 0; i < NP; i++)
            if (uen[i] && upins[i*P +: P] == pin) return {5'b1_0001, 2'(i)};
        return 7'b1_1000_00;
    endfunction

    function automatic int next_fails(input int f, input logic [6:0] e);
        if (e[5]) return (f < MF) ? f + 1 : MF;
        return 0;
    endfunction

    // driver tasks
    task automatic submit(input logic [P-1:0] pin, output int lat, output logic [6:0] obs);
        pin_digits = pin;
        pin_valid  = 1'b1;
        step();
        pin_valid = 1'b0;
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        obs = obs_now();
    endtask

    task automatic ack();
        res_ack = 1'b1;
        step();
        res_ack = 1'b0;
    endtask

    task automatic expect_push(input logic [P-1:0] pin);
        logic [6:0] e;
        e = model(pin);
        exp_q.push_back(e);
        m_fails = next_fails(m_fails, e);
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_total++;
        if (obs_now() !== 7'd0) $display("FAIL reset_res: got %b want 0", obs_now()); else n_pass++;
        n_total++;
        if ({locked, fail_count} !== 3'd0) $display("FAIL reset_lock: got %b want 000", {locked, fail_count}); else n_pass++;
        rst = 1'b0;
        repeat (4) step();
        n_total++;
        if (res_valid !== 1'b0) $display("FAIL reset_held_pv: got %b want 0", res_valid); else n_pass++;
        pin_valid = 1'b0;
        step();
    endtask

    task automatic test_default();
        int lat; logic [6:0] obs, e;
        ms = 1'b0; mpin = 16'h9999; uen = '0;
        expect_push(16'h1234);
        submit(16'h1234, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (lat !== 2) $display("FAIL latency: got %0d want 2", lat); else n_pass++;
        n_total++;
        if (obs !== e) $display("FAIL default_ok: got %b want %b", obs, e); else n_pass++;
        ack();
        n_total++;
        if (obs_now() !== 7'd0) $display("FAIL ack_clear: got %b want 0", obs_now()); else n_pass++;
        expect_push(16'h1235);
        submit(16'h1235, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL default_bad: got %b want %b", obs, e); else n_pass++;
        n_total++;
        if (fail_count !== 2'(m_fails)) $display("FAIL fail_cnt1: got %0d want %0d", fail_count, m_fails); else n_pass++;
        ack();
        step();
    endtask

    task automatic test_user();
        int lat; logic [6:0] obs, e;
        ms = 1'b1; mpin = 16'h9999;
        upins = {16'h5555, 16'h0000, 16'h5555, 16'h0000};
        uen = 4'b1010;
        expect_push(16'h5555);
        submit(16'h5555, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL user_idx1: got %b want %b", obs, e); else n_pass++;
        n_total++;
        if (fail_count !== 2'(m_fails)) $display("FAIL fail_clr: got %0d want %0d", fail_count, m_fails); else n_pass++;
        ack();
        uen = 4'b1000;
        expect_push(16'h5555);
        submit(16'h5555, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL user_idx3: got %b want %b", obs, e); else n_pass++;
        ack();
        // user slot equal to master: master has priority
        upins[1*P +: P] = 16'h9999;
        uen = 4'b0010;
        expect_push(16'h9999);
        submit(16'h9999, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL master_prio: got %b want %b", obs, e); else n_pass++;
        ack();
        step();
    endtask

    task automatic test_early_ack();
        int lat; logic [6:0] obs, e;
        res_ack = 1'b1;
        expect_push(16'h9999);
        submit(16'h9999, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL early_ack_res: got %b want %b", obs, e); else n_pass++;
        step();
        res_ack = 1'b0;
        n_total++;
        if (obs_now() !== 7'd0) $display("FAIL early_ack_clr: got %b want 0", obs_now()); else n_pass++;
        step();
    endtask

    task automatic test_lockout();
        int lat, cnt; logic [6:0] obs, e; logic seen;
        ms = 1'b1; mpin = 16'h9999; uen = '0;
        for (int k = 0; k < MF; k++) begin
            expect_push(16'h0001 + 16'(k));
            submit(16'h0001 + 16'(k), lat, obs);
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e || fail_count !== 2'(m_fails))
                $display("FAIL lock_fail%0d: got %b/%0d want %b/%0d", k, obs, fail_count, e, m_fails);
            else n_pass++;
            ack();
        end
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (locked === 1'b1) cnt++;
            if (res_valid !== 1'b0) seen = 1'b1;
            if (k == 2) begin pin_digits = 16'h9999; pin_valid = 1'b1; end
            if (k == 4) pin_valid = 1'b0;
            step();
        end
        m_fails = 0;
        n_total++;
        if (cnt !== LC) $display("FAIL lock_len: got %0d want %0d", cnt, LC); else n_pass++;
        n_total++;
        if (seen !== 1'b0) $display("FAIL lock_ignore: got %b want 0", seen); else n_pass++;
        n_total++;
        if ({locked, fail_count} !== 3'd0) $display("FAIL lock_exit: got %b want 000", {locked, fail_count}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; logic [6:0] obs, e; logic seen;
        expect_push(16'h0111);
        submit(16'h0111, lat, obs);
        void'(exp_q.pop_front());
        ack();
        expect_push(16'h0222);
        submit(16'h0222, lat, obs);
        void'(exp_q.pop_front());
        n_total++;
        if (fail_count !== 2'(m_fails)) $display("FAIL b2b_two: got %0d want %0d", fail_count, m_fails); else n_pass++;
        ack();
        expect_push(16'h9999);
        submit(16'h9999, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e || fail_count !== 2'(m_fails))
            $display("FAIL b2b_good: got %b/%0d want %b/%0d", obs, fail_count, e, m_fails);
        else n_pass++;
        pin_valid = 1'b1;
        step();
        pin_valid = 1'b0;
        step();
        ack();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL result_pv_drop: got %b want 0", seen); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [6:0] obs, e; logic seen;
        ms = 1'b1; mpin = 16'h9999; uen = '0;
        expect_push(16'h0000);
        submit(16'h0000, lat, obs);
        void'(exp_q.pop_front());
        pin_valid = 1'b1;
        rst = 1'b1;
        #1;
        m_fails = 0;
        n_total++;
        if ({obs_now(), locked, fail_count} !== 10'd0) $display("FAIL rst_result: got %b want 0", {obs_now(), locked, fail_count}); else n_pass++;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_no_replay: got %b want 0", seen); else n_pass++;
        pin_valid = 1'b0;
        step();
        expect_push(16'h9999);
        submit(16'h9999, lat, obs);
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e || lat !== 2) $display("FAIL rst_resubmit: got %b lat %0d want %b lat 2", obs, lat, e); else n_pass++;
        ack();
        for (int k = 0; k < MF; k++) begin
            expect_push(16'h0abc);
            submit(16'h0abc, lat, obs);
            void'(exp_q.pop_front());
            ack();
        end
        step();
        step();
        n_total++;
        if (locked !== 1'b1) $display("FAIL rst_pre_lock: got %b want 1", locked); else n_pass++;
        pin_valid = 1'b1;
        rst = 1'b1;
        #1;
        m_fails = 0;
        n_total++;
        if ({obs_now(), locked, fail_count} !== 10'd0) $display("FAIL rst_lockout: got %b want 0", {obs_now(), locked, fail_count}); else n_pass++;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (res_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL rst_lock_replay: got %b want 0", seen); else n_pass++;
        pin_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        int lat, w; logic [6:0] obs, e; logic [P-1:0] pin;
        for (int it = 0; it < 40; it++) begin
            if (it % 8 == 0) begin
                ms    = ($urandom_range(0, 3) != 0);
                mpin  = 16'($urandom);
                for (int s = 0; s < NP; s++) upins[s*P +: P] = 16'($urandom);
                upins[$urandom_range(0, 3)*P +: P] = upins[$urandom_range(0, 3)*P +: P];
                uen   = 4'($urandom);
            end
            case ($urandom_range(0, 4))
                0: pin = mpin;
                1: pin = 16'h1234;
                2: pin = upins[$urandom_range(0, 3)*P +: P];
                default: pin = 16'($urandom);
            endcase
            expect_push(pin);
            submit(pin, lat, obs);
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e || lat !== 2 || fail_count !== 2'(m_fails))
                $display("FAIL rand%0d pin %h: got %b lat %0d fc %0d want %b lat 2 fc %0d",
                         it, pin, obs, lat, fail_count, e, m_fails);
            else n_pass++;
            repeat ($urandom_range(0, 2)) step();
            ack();
            if (m_fails == MF) begin
                w = 0;
                while (locked === 1'b1 && w < LC + 4) begin step(); w++; end
                m_fails = 0;
                n_total++;
                if (w !== LC) $display("FAIL rand_lock%0d: got %0d want %0d", it, w, LC); else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_user();
        test_early_ack();
        test_lockout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
